// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared defaults and entry type for the fetch stage      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned c_WIDTH    = 32;
  localparam int unsigned c_STEP     = 4;
  localparam int unsigned c_RESET_PC = 0;

  typedef struct packed {
    logic [c_WIDTH-1:0] pc;
    logic [c_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_fetch_q_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_fetch_q_if : imem, redirect and decode-side handshake bundle   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface pipe_fetch_q_if
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = c_WIDTH,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_inst;
  logic [WIDTH-1:0] out_pc;
  logic [LVL_W-1:0] level;

  modport master (
    output imem_addr, out_valid, out_inst, out_pc, level,
    input  imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_inst, out_pc, level,
    output imem_data, redirect, redirect_pc, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with flush and async active-low clear |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = $clog2(DEPTH),
  parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  wire logic              clk,
  input  wire logic              clrn,
  input  wire logic              flush,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] rdata,
  output logic                   valid,
  output logic                   full,
  output logic      [LVL_W-1:0]  level
);
  localparam logic [LVL_W-1:0] c_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [LVL_W-1:0]  r_level;

  // Flush outranks both push and pop; a same-cycle pop is simply lost.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      if (pop)  r_head <= r_head + 1'b1;
      if (push && !pop)      r_level <= r_level + 1'b1;
      else if (!push && pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_tail] <= wdata;
  end

  assign rdata = r_mem[r_head];
  assign valid = (r_level != '0);
  assign full  = (r_level == c_FULL);
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/pipe_fetch_q.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_fetch_q : PC register, incrementer and decoupling fetch queue  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pipe_fetch_q
  import fetch_pkg::*;
#(
  parameter int unsigned     WIDTH    = c_WIDTH,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(c_RESET_PC),
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(c_STEP)
) (
  input wire logic        clk,
  input wire logic        clrn,
  pipe_fetch_q_if.master  bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_pc;
  logic               w_pop;
  logic               w_push;
  logic               w_valid;
  logic               w_full;
  logic [2*WIDTH-1:0] w_rdata;
  logic [LVL_W-1:0]   w_level;

  assign w_pop  = w_valid & bus.out_ready;
  // A full queue can still take a fetch when the head leaves this cycle.
  assign w_push = ~bus.redirect & (~w_full | w_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)             r_pc <= RESET_PC;
    else if (bus.redirect) r_pc <= bus.redirect_pc;
    else if (w_push)       r_pc <= r_pc + STEP;
  end

  fetch_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .flush (bus.redirect),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({r_pc, bus.imem_data}),
    .rdata (w_rdata),
    .valid (w_valid),
    .full  (w_full),
    .level (w_level)
  );

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_rdata[2*WIDTH-1:WIDTH];
  assign bus.out_inst  = w_rdata[WIDTH-1:0];
  assign bus.level     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_q.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_fetch_q : directed checks for the fetch stage and its queue |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pipe_fetch_q;

  logic clk;
  logic clrn;
  int   nAssert;
  int   nFail;

  pipe_fetch_q_if #(.WIDTH(32), .DEPTH(4)) bus ();

  pipe_fetch_q #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .STEP     (32'h4)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: contents are address XOR a fixed mask.
  assign bus.imem_data = bus.imem_addr ^ 32'hFFFF0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nAssert = 0;
    nFail   = 0;
    clrn            = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;

    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.level),     32'd0);
    chk("rst_addr",  bus.imem_addr,      32'h0);
    #2 clrn = 1'b1;

    // Backpressure from reset: queue fills after 4 edges, PC parks at 0x10.
    repeat (8) tick();
    chk("full_level", 32'(bus.level),     32'd4);
    chk("full_addr",  bus.imem_addr,      32'h10);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_pc",    bus.out_pc,         32'h0);
    chk("full_inst",  bus.out_inst,       32'hFFFF0000);

    // Full queue with a simultaneous pop keeps the level and advances PC.
    bus.out_ready = 1'b1;
    tick();
    chk("fpop_level", 32'(bus.level), 32'd4);
    chk("fpop_addr",  bus.imem_addr,  32'h14);
    chk("fpop_pc",    bus.out_pc,     32'h4);
    tick();
    chk("drain_pc8",   bus.out_pc,   32'h8);
    chk("drain_inst8", bus.out_inst, 32'hFFFF0008);
    tick();
    chk("drain_pcC",  bus.out_pc, 32'hC);
    tick();
    chk("drain_pc10",   bus.out_pc,   32'h10);
    chk("drain_inst10", bus.out_inst, 32'hFFFF0010);

    // Asynchronous clear between edges while full.
    #2 clrn = 1'b0;
    #1;
    chk("arst4_valid", 32'(bus.out_valid), 32'd0);
    chk("arst4_addr",  bus.imem_addr,      32'h0);
    #1 clrn = 1'b1;

    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("lvl2_level", 32'(bus.level), 32'd2);

    #2 clrn = 1'b0;
    #1;
    chk("arst2_valid", 32'(bus.out_valid), 32'd0);
    chk("arst2_level", 32'(bus.level),     32'd0);
    chk("arst2_addr",  bus.imem_addr,      32'h0);
    #1 clrn = 1'b1;

    repeat (3) tick();
    chk("restart_level", 32'(bus.level), 32'd3);
    chk("restart_pc",    bus.out_pc,     32'h0);
    chk("restart_addr",  bus.imem_addr,  32'hC);

    // Redirect with level 3 and decode ready: the pop is voided.
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("redir_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_level", 32'(bus.level),     32'd0);
    chk("redir_addr",  bus.imem_addr,      32'h100);
    tick();
    chk("redir1_valid", 32'(bus.out_valid), 32'd1);
    chk("redir1_pc",    bus.out_pc,         32'h100);
    chk("redir1_inst",  bus.out_inst,       32'hFFFF0100);
    tick();
    chk("redir2_pc", bus.out_pc, 32'h104);

    // Back-to-back redirects, last one targets the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_pc = 32'hFFFFFFFC;
    tick();
    bus.redirect = 1'b0;
    chk("b2b_valid", 32'(bus.out_valid), 32'd0);
    chk("b2b_level", 32'(bus.level),     32'd0);
    chk("b2b_addr",  bus.imem_addr,      32'hFFFFFFFC);
    tick();
    chk("wrap_pc",   bus.out_pc,    32'hFFFFFFFC);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    tick();
    chk("wrap2_pc",   bus.out_pc,   32'h0);
    chk("wrap2_inst", bus.out_inst, 32'hFFFF0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire
